// File: rtl/fill_pkg.sv
// Shared types and the per-pixel colour rule for the rectangle fill engine.
package fill_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_DRAW,
        S_DONE
    } fill_state_t;

    typedef enum logic [1:0] {
        SOLID,
        COLSTRIPE,
        ROWSTRIPE,
        CHECKER
    } fill_mode_t;

    // Only the low nibble of each coordinate matters for any pattern.
    function automatic logic [2:0] pixel_colour(fill_mode_t mode, logic [2:0] colour,
                                                logic [3:0] xl, logic [3:0] yl);
        case (mode)
            SOLID:     return colour;
            COLSTRIPE: return xl[2:0];
            ROWSTRIPE: return yl[2:0];
            default:   return (xl[3] ^ yl[3]) ? 3'b000 : colour;
        endcase
    endfunction

endpackage

// File: rtl/fill_if.sv
// Request/plot bundle between a fill requester (master) and the fill engine (slave).
interface fill_if;
    import fill_pkg::*;

    logic       start;
    fill_mode_t mode;
    logic [2:0] colour;
    logic [7:0] x0;
    logic [7:0] x1;
    logic [6:0] y0;
    logic [6:0] y1;
    logic       hold;
    logic       busy;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        output start, mode, colour, x0, x1, y0, y1, hold,
        input  busy, done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, mode, colour, x0, x1, y0, y1, hold,
        output busy, done, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/raster_counter.sv
// Column-major x/y walker over an inclusive rectangle; flags the final (x1,y1) pixel.
module raster_counter (
    input  logic       clk,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [7:0] x1,
    input  logic [6:0] y1,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       last
);

    always_ff @(posedge clk) begin
        if (load) begin
            x <= x0;
            y <= y0;
        end else if (en) begin
            if (y == y1) begin
                y <= y0;
                x <= x + 8'd1;
            end else begin
                y <= y + 7'd1;
            end
        end
    end

    assign last = (x == x1) && (y == y1);

endmodule

// File: rtl/fill_engine.sv
// Rectangle fill FSM: latches a request, clips it to the screen and emits one plot per cycle.
module fill_engine
    import fill_pkg::*;
#(
    parameter int XMAX = SCREEN_W,
    parameter int YMAX = SCREEN_H
) (
    input  logic   clk,
    input  logic   rst,
    fill_if.slave  bus
);

    localparam logic [7:0] X_LIM = 8'(XMAX - 1);
    localparam logic [6:0] Y_LIM = 7'(YMAX - 1);

    fill_state_t state;
    fill_mode_t  mode_l;
    logic [2:0]  colour_l;
    logic [7:0]  x0_l, x1_l;
    logic [6:0]  y0_l, y1_l;
    logic [7:0]  x1_c, cur_x;
    logic [6:0]  y1_c, cur_y;
    logic        empty, last;
    logic        busy_r, done_r, plot_r;
    logic [7:0]  vx_r;
    logic [6:0]  vy_r;
    logic [2:0]  vc_r;

    // Bounds are frozen after the start edge, so the clamp can stay combinational.
    assign x1_c  = (x1_l > X_LIM) ? X_LIM : x1_l;
    assign y1_c  = (y1_l > Y_LIM) ? Y_LIM : y1_l;
    assign empty = (x0_l > X_LIM) || (y0_l > Y_LIM) || (x0_l > x1_c) || (y0_l > y1_c);

    raster_counter u_raster (
        .clk  (clk),
        .load (state == S_SETUP),
        .en   ((state == S_DRAW) && !bus.hold),
        .x0   (x0_l),
        .y0   (y0_l),
        .x1   (x1_c),
        .y1   (y1_c),
        .x    (cur_x),
        .y    (cur_y),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            plot_r <= 1'b0;
            vx_r   <= '0;
            vy_r   <= '0;
            vc_r   <= '0;
        end else begin
            busy_r <= (state == S_SETUP) || (state == S_DRAW);
            // done lags the DONE state by one cycle and drops on the same edge we return to IDLE.
            done_r <= (state == S_DONE) && !(done_r && !bus.start);
            plot_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mode_l   <= bus.mode;
                        colour_l <= bus.colour;
                        x0_l     <= bus.x0;
                        x1_l     <= bus.x1;
                        y0_l     <= bus.y0;
                        y1_l     <= bus.y1;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: state <= empty ? S_DONE : S_DRAW;
                S_DRAW: begin
                    if (!bus.hold) begin
                        plot_r <= 1'b1;
                        vx_r   <= cur_x;
                        vy_r   <= cur_y;
                        vc_r   <= pixel_colour(mode_l, colour_l, cur_x[3:0], cur_y[3:0]);
                        if (last) state <= S_DONE;
                    end
                end
                S_DONE: if (done_r && !bus.start) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.vga_plot   = plot_r;
    assign bus.vga_x      = vx_r;
    assign bus.vga_y      = vy_r;
    assign bus.vga_colour = vc_r;

endmodule

// File: tb/tb_fill_engine.sv
// Directed bench for fill_engine: table of fills checked against a traversal/colour model.
module tb_fill_engine;
    import fill_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    fill_if bus ();

    fill_engine #(.XMAX(160), .YMAX(120)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        fill_mode_t mode;
        logic [2:0] colour;
        int         x0, x1, y0, y1;
        int         cy1;
        int         exp_n;
        int         exp_lat;
        int         exp_last_x;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [2:0] exp_col(fill_mode_t m, logic [2:0] c, int x, int y);
        case (m)
            SOLID:     return c;
            COLSTRIPE: return 3'(x % 8);
            ROWSTRIPE: return 3'(y % 8);
            default:   return (((x / 8) % 2) != ((y / 8) % 2)) ? 3'b000 : c;
        endcase
    endfunction

    task automatic run_fill(input vec_t v, input int h1, input int h2lo, input int h2hi);
        int    ex, ey, nplot, lat, perr, lastx;
        string first;
        ex = v.x0; ey = v.y0; nplot = 0; lat = -1; perr = 0; lastx = -1; first = "none";
        bus.mode   = v.mode;
        bus.colour = v.colour;
        bus.x0     = 8'(v.x0);
        bus.x1     = 8'(v.x1);
        bus.y0     = 7'(v.y0);
        bus.y1     = 7'(v.y1);
        bus.hold   = 1'b0;
        bus.start  = 1'b1;
        tick();
        chk({v.name, " busy_e0"}, int'(bus.busy), 0);
        for (int i = 1; i <= v.exp_lat + 20; i++) begin
            bus.hold = (i == h1) || (i >= h2lo && i <= h2hi);
            tick();
            if (i == 1) chk({v.name, " busy_e1"}, int'(bus.busy), 1);
            if (bus.vga_plot) begin
                if (nplot >= v.exp_n || int'(bus.vga_x) != ex || int'(bus.vga_y) != ey ||
                    bus.vga_colour != exp_col(v.mode, v.colour, ex, ey)) begin
                    if (perr == 0)
                        first = $sformatf("#%0d got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)", nplot,
                                          bus.vga_x, bus.vga_y, bus.vga_colour, ex, ey,
                                          exp_col(v.mode, v.colour, ex, ey));
                    perr++;
                end
                lastx = int'(bus.vga_x);
                nplot++;
                if (ey == v.cy1) begin
                    ey = v.y0;
                    ex++;
                end else begin
                    ey++;
                end
            end
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        bus.hold = 1'b0;
        chk({v.name, " plots"}, nplot, v.exp_n);
        chk({v.name, " pixel_errors first=", first}, perr, 0);
        chk({v.name, " done_latency"}, lat, v.exp_lat);
        chk({v.name, " last_x"}, lastx, v.exp_last_x);
        tick();
        chk({v.name, " done_while_start_held"}, int'({bus.done, bus.vga_plot, bus.busy}), 3'b100);
        bus.start = 1'b0;
        tick();
        chk({v.name, " idle_after_start_low"}, int'({bus.done, bus.busy}), 2'b00);
    endtask

    initial begin
        int   nplot;
        vec_t hv, rv;

        tbl[0] = '{"full_colstripe", COLSTRIPE, 3'd0,   0, 159,   0, 119, 119, 19200, 19202, 159};
        tbl[1] = '{"rect_solid",     SOLID,     3'd3,   2,   3,   3,   4,   4,     4,     6,   3};
        tbl[2] = '{"clamp_checker",  CHECKER,   3'd6, 150, 200, 118, 119, 119,    20,    22, 159};
        tbl[3] = '{"empty_x",        SOLID,     3'd1,  10,   5,   0,   3,   3,     0,     2,  -1};
        tbl[4] = '{"empty_y",        SOLID,     3'd1,   0,   5, 120, 125, 119,     0,     2,  -1};
        tbl[5] = '{"single_corner",  ROWSTRIPE, 3'd0, 159, 159, 119, 119, 119,     1,     3, 159};
        tbl[6] = '{"checker_4x4",    CHECKER,   3'd7,   6,   9,   6,   9,   9,    16,    18,   9};
        hv     = '{"hold_4x4",       SOLID,     3'd5,   0,   3,   0,   3,   3,    16,    22,   3};
        rv     = '{"after_reset",    ROWSTRIPE, 3'd0,   0,   0,   0,   7,   7,     8,    10,   0};

        bus.start = 1'b0; bus.hold = 1'b0; bus.mode = SOLID; bus.colour = 3'd0;
        bus.x0 = 8'd0; bus.x1 = 8'd0; bus.y0 = 7'd0; bus.y1 = 7'd0;
        rst = 1'b1;
        tick();
        tick();
        chk("reset_outputs", int'({bus.busy, bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 7; k++) run_fill(tbl[k], -1, -1, -2);

        // One-cycle hold at edge 5 and a three-cycle hold at edges 9..11.
        run_fill(hv, 5, 9, 11);

        // Abandon a full-screen fill after 50 plots; reset arrives with start still high.
        bus.mode = COLSTRIPE; bus.colour = 3'd0;
        bus.x0 = 8'd0; bus.x1 = 8'd159; bus.y0 = 7'd0; bus.y1 = 7'd119;
        bus.start = 1'b1;
        nplot = 0;
        for (int i = 0; i < 200 && nplot < 50; i++) begin
            tick();
            if (bus.vga_plot) nplot++;
        end
        chk("plots_before_reset", nplot, 50);
        rst = 1'b1;
        tick();
        chk("outputs_after_midfill_reset",
            int'({bus.busy, bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
        rst = 1'b0;
        bus.start = 1'b0;
        tick();
        tick();
        chk("idle_after_reset", int'({bus.busy, bus.done, bus.vga_plot}), 0);
        run_fill(rv, -1, -1, -2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fill_engine.md
# fill_engine

Rectangle fill engine for the 160x120 VGA plot path. It sits directly upstream of the VGA adapter inside the task2 top level and produces one `vga_x`/`vga_y`/`vga_colour`/`vga_plot` command per cycle. It fills a latched, clipped rectangle in column-major order with a solid colour or a positional pattern, and reports completion through a start/done handshake.

## Interface
- `XMAX`, default 160: screen width in pixels.
- `YMAX`, default 120: screen height in pixels.
- `clk`  in  1: single clock (CLOCK_50 at top level).
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a fill; sampled only in IDLE.
- `mode`  in  2: 0 solid, 1 column stripes, 2 row stripes, 3 checker; latched at start.
- `colour`  in  3: fill colour; latched at start.
- `x0`, `x1`  in  8: inclusive column bounds; latched at start.
- `y0`, `y1`  in  7: inclusive row bounds; latched at start.
- `hold`  in  1: stall; while 1 no pixel is issued and position is frozen.
- `busy`  out  1: high in SETUP and DRAW.
- `done`  out  1: high in DONE.
- `vga_x`  out  8, `vga_y`  out  7, `vga_colour`  out  3, `vga_plot`  out  1: registered plot command.
- One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, SETUP, DRAW, DONE.
- IDLE: `start`=1 at an edge latches mode, colour and bounds, then goes to SETUP.
- SETUP: clamp `x1` to min(x1, XMAX-1) and `y1` to min(y1, YMAX-1). `x0` ≥ XMAX or `y0` ≥ YMAX, or `x0` > clamped `x1`, or `y0` > clamped `y1`, means an empty fill and goes to DONE. Otherwise load x=x0, y=y0 and go to DRAW.
- DRAW, `hold`=0: issue pixel (x,y). Traversal is column-major: y increments to `y1`, then resets to `y0` while x increments. After issuing (x1,y1), go to DONE.
- DRAW, `hold`=1: no pixel issued, x/y unchanged, state unchanged.
- Colour rule (x, y are the issued coordinates):
  - mode 0: `colour`.
  - mode 1: x[2:0].
  - mode 2: y[2:0].
  - mode 3: `colour` if x[3]^y[3]=0, else 3'b000.
- DONE: `done`=1 until `start` is seen low, then IDLE. A held-high `start` never retriggers.
- `hold` is ignored outside DRAW.
- Reset in any state: immediate IDLE and the current fill is abandoned. Reset dominates `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `vga_plot`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0.
- `start` sampled at edge E0. SETUP occupies E0..E1. First `vga_plot`=1 is visible after E2.
- With no `hold`, N pixels appear on N consecutive cycles (after E2..E(N+1)). `done`=1 and `vga_plot`=0 are visible after E(N+2).
- Full screen takes N=19200 pixels.
- Each `hold` cycle in DRAW inserts exactly one cycle with `vga_plot`=0 and delays `done` by one cycle.
- Empty fill: `done` visible after E2 and `vga_plot` never asserts.
- `vga_x`/`vga_y`/`vga_colour` hold their last value while `vga_plot`=0. Only `vga_plot`=1 cycles are meaningful downstream.
- `busy` is visible after E1, through the cycle before `done` rises.

## Structure
- Package `fill_pkg`:
  - state enum `fill_state_t`;
  - mode enum `fill_mode_t` (SOLID, COLSTRIPE, ROWSTRIPE, CHECKER);
  - constants `SCREEN_W`=160, `SCREEN_H`=120;
  - colour-rule function.
- Sub-module `raster_counter`: owns the x/y registers, load, advance-with-enable, and the `last` flag for (x1,y1).
- `fill_engine`: owns the FSM, clamping, and the output registers.

## Test plan
- Full screen, mode 1: x0=0,y0=0,x1=159,y1=119 → exactly 19200 plots. Pixel 0 is (0,0) colour 0. Pixel 120 is (1,0) colour 1. Pixel (13,7) has colour 5. `done` is visible 19202 cycles after start is sampled.
- Rect (2,3)-(3,4), mode 0, colour 3 → plots in order (2,3),(2,4),(3,3),(3,4), all colour 3. Then `done`=1 while `start` is held; IDLE one cycle after `start` drops.
- Clamp and empty:
  - x0=150,x1=200,y0=118,y1=119 → 20 plots, x runs 150..159.
  - x0=10,x1=5 → no plots, `done` after E2.
- `hold` pulses of 1 and 3 cycles mid-fill on a 4x4 rect → 16 unique plots, none duplicated or skipped, and 4 extra cycles to `done`.
- `rst` asserted after 50 plots of a full-screen fill → next cycle all outputs are 0 and the state is IDLE. A new start, mode 2, rect (0,0)-(0,7) → colours 0..7.
